// File: rtl/layer_stream_sequencer.sv
// Captures one layer's NN parallel neuron results and replays them as a serial word stream.
// Optional ARGMAX_EN macro adds a running signed argmax that reports the winning neuron index.
module layer_stream_sequencer #(
    parameter int NN         = 10,
    parameter int DATA_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NN-1:0]             in_valid,
    input  logic [NN*DATA_WIDTH-1:0]  in_data,
    input  logic                      err_clr,
    output logic                      out_valid,
    output logic [DATA_WIDTH-1:0]     out_data,
    output logic                      out_last,
    output logic                      busy,
    output logic                      err_mismatch,
    output logic                      err_overrun,
    output logic [$clog2(NN)-1:0]     class_idx,
    output logic                      class_valid
);
    localparam int CW = $clog2(NN);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t                state_reg;
    logic [CW-1:0]         count_reg;
    logic [DATA_WIDTH-1:0] buf_reg [NN];
    logic [DATA_WIDTH-1:0] in_word [NN];

    logic          cap;
    logic          final_word;
    logic          accept;
    logic          overrun_evt;
    logic          mismatch_evt;
    logic [CW-1:0] count_inc;

    generate
        for (genvar gi = 0; gi < NN; gi++) begin : g_unpack
            assign in_word[gi] = in_data[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    assign cap          = in_valid[0];
    assign final_word   = (state_reg == SHIFT) && (count_reg == CW'(NN-1));
    assign accept       = cap && ((state_reg == IDLE) || final_word);
    assign overrun_evt  = cap && (state_reg == SHIFT) && !final_word;
    assign mismatch_evt = cap && (in_valid != {NN{1'b1}});
    assign count_inc    = count_reg + CW'(1);
    assign busy         = (state_reg == SHIFT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NN; i++) buf_reg[i] <= '0;
        end else if (accept) begin
            for (int i = 0; i < NN; i++) buf_reg[i] <= in_word[i];
        end
    end

    // count_reg always indexes the word currently on out_data, so word 0 is
    // loaded straight from in_data on the capture edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            count_reg <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (cap) begin
                        state_reg <= SHIFT;
                        count_reg <= '0;
                        out_valid <= 1'b1;
                        out_data  <= in_word[0];
                        out_last  <= 1'b0;
                    end
                end
                SHIFT: begin
                    if (final_word) begin
                        count_reg <= '0;
                        out_last  <= 1'b0;
                        if (cap) begin
                            out_data <= in_word[0];
                        end else begin
                            state_reg <= IDLE;
                            out_valid <= 1'b0;
                            out_data  <= '0;
                        end
                    end else begin
                        count_reg <= count_inc;
                        out_data  <= buf_reg[count_inc];
                        out_last  <= (count_inc == CW'(NN-1));
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_mismatch <= 1'b0;
            err_overrun  <= 1'b0;
        end else begin
            err_mismatch <= mismatch_evt | (err_mismatch & ~err_clr);
            err_overrun  <= overrun_evt  | (err_overrun  & ~err_clr);
        end
    end

`ifdef ARGMAX_EN
    logic signed [DATA_WIDTH-1:0] max_reg;
    logic [CW-1:0]                max_idx_reg;
    logic                         take;
    logic [CW-1:0]                idx_now;

    // Strictly greater replaces, so ties stay with the lower neuron index.
    assign take    = (count_reg == '0) || ($signed(out_data) > max_reg);
    assign idx_now = take ? count_reg : max_idx_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            max_reg     <= '0;
            max_idx_reg <= '0;
            class_idx   <= '0;
            class_valid <= 1'b0;
        end else begin
            class_valid <= 1'b0;
            if (out_valid && take) begin
                max_reg     <= $signed(out_data);
                max_idx_reg <= count_reg;
            end
            if (out_valid && out_last) begin
                class_idx   <= idx_now;
                class_valid <= 1'b1;
            end
        end
    end
`else
    assign class_idx   = '0;
    assign class_valid = 1'b0;
`endif

endmodule

// File: tb/tb_layer_stream_sequencer.sv
// Scoreboard bench for layer_stream_sequencer: directed scenarios then random capture traffic,
// checked against a word-queue reference model.
module tb_layer_stream_sequencer;
    localparam int NN = 10;
    localparam int DW = 16;
    localparam int CW = $clog2(NN);

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NN-1:0]        in_valid = '0;
    logic [NN*DW-1:0]     in_data = '0;
    logic                 err_clr = 1'b0;
    logic                 out_valid;
    logic [DW-1:0]        out_data;
    logic                 out_last;
    logic                 busy;
    logic                 err_mismatch;
    logic                 err_overrun;
    logic [CW-1:0]        class_idx;
    logic                 class_valid;

    layer_stream_sequencer #(.NN(NN), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .err_clr(err_clr),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last), .busy(busy),
        .err_mismatch(err_mismatch), .err_overrun(err_overrun),
        .class_idx(class_idx), .class_valid(class_valid)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: queued expected words and a count of words still to be shown.
    logic [DW-1:0] exp_data_q [$];
    logic          exp_last_q [$];
    int            exp_cls_q  [$];
    int            m_rem = 0;
    logic          m_mis = 1'b0;
    logic          m_ovr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int argmax_of(input logic [NN*DW-1:0] d);
        int best = 0;
        for (int i = 1; i < NN; i++)
            if ($signed(d[i*DW +: DW]) > $signed(d[best*DW +: DW])) best = i;
        return best;
    endfunction

    function automatic logic [NN*DW-1:0] ramp(input int base);
        logic [NN*DW-1:0] d;
        for (int i = 0; i < NN; i++) d[i*DW +: DW] = DW'(base + i);
        return d;
    endfunction

    // Checks the previous edge's effect, then presents inputs for the next edge.
    task automatic step(input logic [NN-1:0] v, input logic [NN*DW-1:0] d, input logic clr);
        logic cap;
        logic mis_evt;
        logic ovr_evt;
        @(posedge clk);
        #1;
        chk("busy", busy, m_rem > 0);
        chk("err_mismatch", err_mismatch, m_mis);
        chk("err_overrun", err_overrun, m_ovr);
        in_valid = v;
        in_data  = d;
        err_clr  = clr;
        cap      = v[0];
        mis_evt  = cap && (v != {NN{1'b1}});
        ovr_evt  = 1'b0;
        if (cap && m_rem <= 1) begin
            for (int i = 0; i < NN; i++) begin
                exp_data_q.push_back(d[i*DW +: DW]);
                exp_last_q.push_back(i == NN-1);
            end
            exp_cls_q.push_back(argmax_of(d));
            m_rem = NN;
        end else begin
            ovr_evt = cap;
            if (m_rem > 0) m_rem--;
        end
        m_mis = mis_evt | (m_mis & ~clr);
        m_ovr = ovr_evt | (m_ovr & ~clr);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, '0, 1'b0);
    endtask

    task automatic rst_pulse();
        @(posedge clk);
        #1;
        rst      = 1'b1;
        in_valid = '0;
        err_clr  = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        exp_data_q.delete();
        exp_last_q.delete();
        exp_cls_q.delete();
        m_rem = 0;
        m_mis = 1'b0;
        m_ovr = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [NN*DW-1:0] amx;
        int sel;
        logic [NN-1:0] v;

        fork
            forever begin
                @(negedge clk);
                if (!rst) begin
                    if (out_valid) begin
                        if (exp_data_q.size() == 0) begin
                            chk("stray_word", 1, 0);
                        end else begin
                            $display("word data=%0h last=%0b", out_data, out_last);
                            chk("out_data", out_data, exp_data_q.pop_front());
                            chk("out_last", out_last, exp_last_q.pop_front());
                        end
                    end
                    if (class_valid) begin
`ifdef ARGMAX_EN
                        if (exp_cls_q.size() == 0) chk("stray_class", 1, 0);
                        else chk("class_idx", class_idx, exp_cls_q.pop_front());
`else
                        chk("class_valid_tied", class_valid, 0);
`endif
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1;
        chk("reset_out_valid", out_valid, 0);
        chk("reset_out_data", out_data, 0);
        chk("reset_out_last", out_last, 0);
        chk("reset_busy", busy, 0);
        chk("reset_err_mismatch", err_mismatch, 0);
        chk("reset_err_overrun", err_overrun, 0);
        chk("reset_class_valid", class_valid, 0);
        chk("reset_class_idx", class_idx, 0);
        rst = 1'b0;

        // Single vector 1..10
        step('1, ramp(1), 1'b0);
        idle(NN + 2);
        // Back-to-back: second capture on the out_last cycle
        step('1, ramp(20), 1'b0);
        idle(NN - 1);
        step('1, ramp(40), 1'b0);
        idle(NN + 2);
        // Overrun three cycles into a replay, then clear
        step('1, ramp(60), 1'b0);
        idle(2);
        step('1, ramp(100), 1'b0);
        idle(NN + 1);
        step('0, '0, 1'b1);
        idle(2);
        // Mismatched valid vector still replays
        step(NN'(1), ramp(80), 1'b0);
        idle(NN + 2);
        step('0, '0, 1'b1);
        idle(1);
        // Reset on the 5th word
        step('1, ramp(120), 1'b0);
        idle(4);
        rst_pulse();
        idle(NN + 2);
        // Argmax tie case
        amx = '0;
        sel = 0;
        foreach (amx[i]) sel = sel;
        amx[0*DW +: DW] = -16'sd3; amx[1*DW +: DW] = 16'sd7;  amx[2*DW +: DW] = 16'sd2;
        amx[3*DW +: DW] = 16'sd7;  amx[4*DW +: DW] = 16'sd0;  amx[5*DW +: DW] = 16'sd1;
        amx[6*DW +: DW] = -16'sd5; amx[7*DW +: DW] = 16'sd4;  amx[8*DW +: DW] = 16'sd3;
        amx[9*DW +: DW] = -16'sd1;
        step('1, amx, 1'b0);
        idle(NN + 2);

        // Random traffic
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(0, 299) == 0) begin
                rst_pulse();
            end else begin
                v = NN'($urandom) & ~NN'(1);
                if ($urandom_range(0, 3) == 0) begin
                    v = ($urandom_range(0, 4) == 0) ? (NN'($urandom) | NN'(1)) : '1;
                end
                for (int i = 0; i < NN; i++) amx[i*DW +: DW] = DW'($urandom);
                step(v, amx, $urandom_range(0, 15) == 0);
            end
        end

        idle(NN + 3);
        chk("drain_words", exp_data_q.size(), 0);
`ifdef ARGMAX_EN
        chk("drain_class", exp_cls_q.size(), 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
